mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_ctrl_units.sv | 59 +++++
 rtl/mem_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared processor definitions: opcode constants plus memory controller
// state encodings, the default bus timeout and the timeout read value.
// Pure declarations, no logic.
package mem_ctrl_pkg;

    // Opcode constants (instruction decode).
    localparam logic [5:0] OP_ALU   = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JMP   = 6'h02;

    // Memory controller FSM encodings.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam int          MEM_TIMEOUT_DFLT = 255;
    localparam logic [31:0] MEM_ERR_DATA     = 32'hDEAD_BEEF;
    localparam int          WAIT_CNT_W       = 8;

    // Terminal count for the wait counter: the last BUS cycle index before
    // timing out. Values above 256 clip to the 8-bit saturation point.
    function automatic logic [WAIT_CNT_W-1:0] wait_limit(input int timeout);
        if (timeout <= 1) begin
            return '0;
        end else if (timeout >= 256) begin
            return '1;
        end else begin
            return WAIT_CNT_W'(timeout - 1);
        end
    endfunction

endpackage

// File: rtl/mem_ctrl_units.sv
// Building blocks for the memory controller: saturating wait counter with a
// terminal-count flag, and the generic 32-bit enable register.
// Both are single-cycle registers; no backpressure.
import mem_ctrl_pkg::*;

module wait_counter #(
    parameter logic [WAIT_CNT_W-1:0] LIMIT = 8'd254
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Next count: clear wins, increment stops at all-ones so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LIMIT);
endmodule

module reg_en32 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);
    logic [31:0] q_q;

    // Load on enable, otherwise hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: turns a single datapath request into one bus access with ack timeout.
// Latency: oRdy two cycles after iReq at minimum, plus one per bus wait cycle.
// Backpressure: iReq only accepted in IDLE; requests in BUS/DONE are dropped, not queued.
import mem_ctrl_pkg::*;

module mem_ctrl #(
    parameter int          TIMEOUT  = MEM_TIMEOUT_DFLT,
    parameter logic [31:0] ERR_DATA = MEM_ERR_DATA
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq,
    input  logic        iWr,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic [31:0] oData,
    output logic        oRdy,
    output logic        oErr,
    output logic        oBusy,
    output logic [31:0] oBusAddr,
    output logic [31:0] oBusWData,
    output logic        oBusRd,
    output logic        oBusWr,
    input  logic        iBusAck,
    input  logic [31:0] iBusRData
);
    mem_state_e  state_q, state_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;

    logic        accept;
    logic        in_bus;
    logic        tc;
    logic        cnt_en;
    logic        data_en;
    logic [31:0] data_in;

    // A request is taken only from IDLE; everything else is latched from it.
    assign accept  = (state_q == ST_IDLE) && iReq;
    assign in_bus  = (state_q == ST_BUS);
    // Ack takes priority over the terminal count, so count only when neither fires.
    assign cnt_en  = in_bus && !iBusAck && !tc;
    // Reads update oData when leaving BUS: bus data on ack, error pattern on timeout.
    assign data_en = in_bus && !wr_q && (iBusAck || tc);
    assign data_in = iBusAck ? iBusRData : ERR_DATA;

    wait_counter #(
        .LIMIT (wait_limit(TIMEOUT))
    ) u_wait (
        .clk_i (iClk),
        .rst_i (iRst),
        .clr_i (accept),
        .en_i  (cnt_en),
        .tc_o  (tc)
    );

    reg_en32 u_addr (
        .clk_i (iClk),
        .rst_i (iRst),
        .en_i  (accept),
        .d_i   (iAddr),
        .q_o   (oBusAddr)
    );

    reg_en32 u_wdata (
        .clk_i (iClk),
        .rst_i (iRst),
        .en_i  (accept),
        .d_i   (iWData),
        .q_o   (oBusWData)
    );

    reg_en32 u_rdata (
        .clk_i (iClk),
        .rst_i (iRst),
        .en_i  (data_en),
        .d_i   (data_in),
        .q_o   (oData)
    );

    // Next state, latched direction/error flag, and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        err_d   = err_q;
        oRdy    = 1'b0;
        oErr    = 1'b0;
        oBusy   = 1'b1;
        oBusRd  = 1'b0;
        oBusWr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                oBusy = 1'b0;
                if (iReq) begin
                    wr_d    = iWr;
                    err_d   = 1'b0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                oBusRd = !wr_q;
                oBusWr = wr_q;
                if (iBusAck) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (tc) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                oRdy    = 1'b1;
                oErr    = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control flags; reset abandons any access in flight.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: main instance with TIMEOUT=4, a second with TIMEOUT=1.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants per step.
module tb_mem_ctrl;
    logic        iClk = 1'b0;
    logic        iRst;
    logic        iReq;
    logic        iWr;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic        iBusAck;
    logic [31:0] iBusRData;

    logic [31:0] oData, oBusAddr, oBusWData;
    logic        oRdy, oErr, oBusy, oBusRd, oBusWr;

    logic [31:0] u1_data, u1_baddr, u1_bwdata;
    logic        u1_rdy, u1_err, u1_busy, u1_brd, u1_bwr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 iClk = ~iClk;

    mem_ctrl #(.TIMEOUT(4)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iReq      (iReq),
        .iWr       (iWr),
        .iAddr     (iAddr),
        .iWData    (iWData),
        .oData     (oData),
        .oRdy      (oRdy),
        .oErr      (oErr),
        .oBusy     (oBusy),
        .oBusAddr  (oBusAddr),
        .oBusWData (oBusWData),
        .oBusRd    (oBusRd),
        .oBusWr    (oBusWr),
        .iBusAck   (iBusAck),
        .iBusRData (iBusRData)
    );

    mem_ctrl #(.TIMEOUT(1)) dut1 (
        .iClk      (iClk),
        .iRst      (iRst),
        .iReq      (iReq),
        .iWr       (iWr),
        .iAddr     (iAddr),
        .iWData    (iWData),
        .oData     (u1_data),
        .oRdy      (u1_rdy),
        .oErr      (u1_err),
        .oBusy     (u1_busy),
        .oBusAddr  (u1_baddr),
        .oBusWData (u1_bwdata),
        .oBusRd    (u1_brd),
        .oBusWr    (u1_bwr),
        .iBusAck   (iBusAck),
        .iBusRData (iBusRData)
    );

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        iRst = 1'b1; iReq = 1'b0; iWr = 1'b0; iAddr = '0; iWData = '0;
        iBusAck = 1'b0; iBusRData = '0;
        tick(); tick();

        // Reset state
        chk("rst_rdy",   oRdy,      0);
        chk("rst_err",   oErr,      0);
        chk("rst_busy",  oBusy,     0);
        chk("rst_rd",    oBusRd,    0);
        chk("rst_wr",    oBusWr,    0);
        chk("rst_addr",  oBusAddr,  0);
        chk("rst_wdata", oBusWData, 0);
        chk("rst_data",  oData,     0);
        iRst = 1'b0;
        tick();

        // Zero-wait read
        iReq = 1'b1; iWr = 1'b0; iAddr = 32'h10; iWData = 32'h0;
        tick();
        chk("zr_busy", oBusy,    1);
        chk("zr_rd",   oBusRd,   1);
        chk("zr_wr",   oBusWr,   0);
        chk("zr_addr", oBusAddr, 32'h10);
        chk("zr_rdy0", oRdy,     0);
        iReq = 1'b0; iBusAck = 1'b1; iBusRData = 32'h1234_5678;
        tick();
        iBusAck = 1'b0; iBusRData = 32'h0;
        chk("zr_rdy",  oRdy,   1);
        chk("zr_err",  oErr,   0);
        chk("zr_data", oData,  32'h1234_5678);
        chk("zr_rdoff", oBusRd, 0);
        tick();
        chk("zr_idle_rdy",  oRdy,  0);
        chk("zr_idle_busy", oBusy, 0);
        tick();

        // Write with three wait cycles
        iReq = 1'b1; iWr = 1'b1; iAddr = 32'h20; iWData = 32'hA5A5_A5A5;
        tick();
        iReq = 1'b0; iAddr = 32'hFFFF_FFFF; iWData = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_strobe", oBusWr,    1);
            chk("wr_rd_low", oBusRd,    0);
            chk("wr_addr",   oBusAddr,  32'h20);
            chk("wr_wdata",  oBusWData, 32'hA5A5_A5A5);
            chk("wr_rdy0",   oRdy,      0);
            tick();
        end
        chk("wr_strobe4", oBusWr,    1);
        chk("wr_addr4",   oBusAddr,  32'h20);
        chk("wr_wdata4",  oBusWData, 32'hA5A5_A5A5);
        iBusAck = 1'b1;
        tick();
        iBusAck = 1'b0;
        chk("wr_rdy",   oRdy,   1);
        chk("wr_err",   oErr,   0);
        chk("wr_data",  oData,  32'h1234_5678);
        chk("wr_wroff", oBusWr, 0);
        tick();
        chk("wr_idle", oBusy, 0);
        tick();

        // Read timeout (TIMEOUT=4 main, TIMEOUT=1 second instance)
        iReq = 1'b1; iWr = 1'b0; iAddr = 32'h30;
        tick();
        iReq = 1'b0;
        chk("t1_rd", u1_brd, 1);
        for (int i = 0; i < 4; i++) begin
            chk("to_rd",   oBusRd, 1);
            chk("to_rdy0", oRdy,   0);
            chk("to_err0", oErr,   0);
            tick();
            if (i == 0) begin
                chk("t1_rdy",  u1_rdy,  1);
                chk("t1_err",  u1_err,  1);
                chk("t1_data", u1_data, 32'hDEAD_BEEF);
            end
        end
        chk("to_rdy",   oRdy,   1);
        chk("to_err",   oErr,   1);
        chk("to_data",  oData,  32'hDEAD_BEEF);
        chk("to_rdoff", oBusRd, 0);
        tick();
        chk("to_err_idle", oErr, 0);
        chk("to_rdy_idle", oRdy, 0);
        tick();

        // Ack on the final timeout cycle
        iReq = 1'b1; iWr = 1'b0; iAddr = 32'h40;
        tick();
        iReq = 1'b0;
        tick(); tick(); tick();
        chk("fa_rd", oBusRd, 1);
        iBusAck = 1'b1; iBusRData = 32'h1;
        tick();
        iBusAck = 1'b0; iBusRData = 32'h0;
        chk("fa_rdy",  oRdy,  1);
        chk("fa_err",  oErr,  0);
        chk("fa_data", oData, 32'h1);
        tick();
        tick();

        // Back-to-back with iReq held high and ack always present
        iReq = 1'b1; iWr = 1'b0; iAddr = 32'h50; iBusAck = 1'b1; iBusRData = 32'h55;
        tick();
        chk("bb_bus1", oBusRd, 1);
        tick();
        chk("bb_rdy1",  oRdy,  1);
        chk("bb_data1", oData, 32'h55);
        iBusRData = 32'h66;
        tick();
        chk("bb_gap_busy", oBusy, 0);
        chk("bb_gap_rdy",  oRdy,  0);
        tick();
        chk("bb_bus2", oBusRd, 1);
        tick();
        chk("bb_rdy2",  oRdy,  1);
        chk("bb_data2", oData, 32'h66);
        iReq = 1'b0; iBusAck = 1'b0; iBusRData = 32'h0;
        tick();
        tick();

        // iReq pulses during BUS are ignored
        iReq = 1'b1; iWr = 1'b0; iAddr = 32'h58;
        tick();
        iReq = 1'b0; iAddr = 32'h99;
        tick();
        iReq = 1'b1;
        chk("ig_rdy0", oRdy, 0);
        tick();
        iReq = 1'b0; iBusAck = 1'b1; iBusRData = 32'h77;
        chk("ig_addr", oBusAddr, 32'h58);
        tick();
        iBusAck = 1'b0;
        chk("ig_rdy", oRdy, 1);
        tick();
        chk("ig_idle", oBusy, 0);
        tick();
        chk("ig_norepeat_rdy",  oRdy,  0);
        chk("ig_norepeat_busy", oBusy, 0);

        // Reset in the second BUS cycle
        iReq = 1'b1; iWr = 1'b0; iAddr = 32'h60;
        tick();
        iReq = 1'b0;
        tick();
        chk("rm_rd", oBusRd, 1);
        #1 iRst = 1'b1;
        #1;
        chk("rm_rd_async",   oBusRd,   0);
        chk("rm_busy_async", oBusy,    0);
        chk("rm_addr_async", oBusAddr, 0);
        chk("rm_data_async", oData,    0);
        tick();
        chk("rm_rdy", oRdy, 0);
        iRst = 1'b0;
        tick();
        chk("rm_rdy_after", oRdy, 0);

        // Clean access after reset
        iReq = 1'b1; iWr = 1'b0; iAddr = 32'h70;
        tick();
        iReq = 1'b0; iBusAck = 1'b1; iBusRData = 32'hCAFE_0001;
        chk("pr_rd",   oBusRd,   1);
        chk("pr_addr", oBusAddr, 32'h70);
        tick();
        iBusAck = 1'b0;
        chk("pr_rdy",  oRdy,  1);
        chk("pr_err",  oErr,  0);
        chk("pr_data", oData, 32'hCAFE_0001);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
